// File: rtl/brew_pkg.sv
// Shared types and the drink recipe table for the brew sequencer.
package brew_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DISPENSE,
        DONE
    } state_t;

    // Valve phases in dispensing order; the encoding doubles as the valve bit index.
    typedef enum logic [2:0] {
        WATER,
        COFFEE,
        SUGAR,
        MILK,
        CHOCOLATE
    } phase_t;

    // Price in 100-unit coins and per-valve durations in one-second ticks.
    typedef struct packed {
        logic [3:0] price;
        logic [1:0] water;
        logic [1:0] coffee;
        logic [1:0] sugar;
        logic [1:0] milk;
        logic [1:0] chocolate;
    } recipe_t;

    localparam logic [2:0] MAX_TYPE = 3'd4;

    localparam recipe_t RECIPE_TABLE [5] = '{
        '{price: 4'd2, water: 2'd2, coffee: 2'd2, sugar: 2'd0, milk: 2'd0, chocolate: 2'd0},
        '{price: 4'd3, water: 2'd1, coffee: 2'd2, sugar: 2'd0, milk: 2'd2, chocolate: 2'd0},
        '{price: 4'd4, water: 2'd1, coffee: 2'd1, sugar: 2'd1, milk: 2'd1, chocolate: 2'd2},
        '{price: 4'd3, water: 2'd2, coffee: 2'd0, sugar: 2'd1, milk: 2'd0, chocolate: 2'd3},
        '{price: 4'd2, water: 2'd2, coffee: 2'd2, sugar: 2'd1, milk: 2'd0, chocolate: 2'd0}
    };

    function automatic logic type_invalid(input logic [2:0] t);
        return t > MAX_TYPE;
    endfunction

    // Invalid selections map to an all-zero recipe; callers gate on type_invalid().
    function automatic recipe_t recipe_lookup(input logic [2:0] t);
        if (type_invalid(t)) begin
            return '0;
        end
        return RECIPE_TABLE[t];
    endfunction

    function automatic logic [1:0] phase_duration(input recipe_t r, input phase_t p);
        case (p)
            WATER:     return r.water;
            COFFEE:    return r.coffee;
            SUGAR:     return r.sugar;
            MILK:      return r.milk;
            CHOCOLATE: return r.chocolate;
            default:   return 2'd0;
        endcase
    endfunction

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            WATER:   return COFFEE;
            COFFEE:  return SUGAR;
            SUGAR:   return MILK;
            MILK:    return CHOCOLATE;
            default: return CHOCOLATE;
        endcase
    endfunction

    // One-hot valve vector for a phase; zero-duration phases keep every valve closed.
    function automatic logic [4:0] valve_mask(input recipe_t r, input phase_t p);
        if (phase_duration(r, p) == 2'd0) begin
            return 5'b00000;
        end
        return 5'b00001 << p;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock into a one-cycle tick every TICK_DIV cycles.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;

    // Free-running modulo-TICK_DIV counter, restarted by clear on phase entry.
    always_ff @(posedge clock) begin
        // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
        if (!reset || clear) begin
            count_q <= '0;
        end else if (count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CW'(1);
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/brew_sequencer.sv
// Coffee machine controller: coin credit, drink validation, change and valve sequencing.
module brew_sequencer
    import brew_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int MAX_CREDIT = 9,
    parameter int DONE_TICKS = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       coin_100,
    input  logic       coin_500,
    input  logic [2:0] coffee_type,
    input  logic       confirm,
    output logic [3:0] credit,
    output logic [3:0] change,
    output logic       water,
    output logic       coffee,
    output logic       sugar,
    output logic       milk,
    output logic       chocolate,
    output logic       finished,
    output logic       busy,
    output logic       error
);

    localparam int TW = 8;

    state_t      state_q, state_n;
    phase_t      phase_q, phase_n;
    logic [2:0]  type_q, type_n;
    logic [TW-1:0] ticks_q, ticks_n;
    logic [3:0]  credit_q, credit_n;
    logic [3:0]  change_q, change_n;
    logic [4:0]  valves_q, valves_n;
    logic        finished_q, finished_n;
    logic        busy_q, busy_n;
    logic        error_q, error_n;

    logic        coin_100_q, coin_500_q, confirm_q;
    logic        coin_100_edge, coin_500_edge, coin_edge, confirm_edge;
    logic [3:0]  coin_add;
    logic [4:0]  credit_sum;
    recipe_t     sel, cur_recipe;
    logic [1:0]  cur_dur;
    phase_t      nxt;
    logic        tick, presc_clear;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clear (presc_clear),
        .tick  (tick)
    );

    // Edge history follows the inputs even in reset, so switches held through reset never fire.
    always_ff @(posedge clock) begin
        // NOTE: these history flops deliberately have no reset branch; loading the live input is their reset value.
        coin_100_q <= coin_100;
        coin_500_q <= coin_500;
        confirm_q  <= confirm;
    end

    assign coin_100_edge = coin_100 & ~coin_100_q;
    assign coin_500_edge = coin_500 & ~coin_500_q;
    assign coin_edge     = coin_100_edge | coin_500_edge;
    assign confirm_edge  = confirm & ~confirm_q;

    assign coin_add   = (coin_100_edge ? 4'd1 : 4'd0) + (coin_500_edge ? 4'd5 : 4'd0);
    assign credit_sum = {1'b0, credit_q} + {1'b0, coin_add};
    assign sel        = recipe_lookup(coffee_type);
    assign cur_recipe = recipe_lookup(type_q);
    assign cur_dur    = phase_duration(cur_recipe, phase_q);
    assign nxt        = next_phase(phase_q);

    // Next-state and registered-output logic for the IDLE / DISPENSE / DONE scheduler.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_n     = state_q;
        phase_n     = phase_q;
        type_n      = type_q;
        ticks_n     = ticks_q;
        credit_n    = credit_q;
        change_n    = change_q;
        valves_n    = valves_q;
        finished_n  = finished_q;
        busy_n      = busy_q;
        error_n     = error_q;
        presc_clear = 1'b0;

        case (state_q)
            IDLE: begin
                presc_clear = 1'b1;
                // A coin edge wins over a coincident confirm so money is never dropped.
                if (coin_edge) begin
                    if (credit_sum > 5'(MAX_CREDIT)) begin
                        credit_n = 4'(MAX_CREDIT);
                    end else begin
                        credit_n = credit_sum[3:0];
                    end
                    change_n = 4'd0;
                    error_n  = 1'b0;
                end else if (confirm_edge) begin
                    if (type_invalid(coffee_type) || (credit_q < sel.price)) begin
                        error_n = 1'b1;
                    end else begin
                        change_n = credit_q - sel.price;
                        credit_n = 4'd0;
                        error_n  = 1'b0;
                        type_n   = coffee_type;
                        phase_n  = WATER;
                        state_n  = DISPENSE;
                        busy_n   = 1'b1;
                        ticks_n  = TW'(sel.water);
                        valves_n = valve_mask(sel, WATER);
                    end
                end
            end

            DISPENSE: begin
                if ((cur_dur == 2'd0) || (tick && (ticks_q == TW'(1)))) begin
                    presc_clear = 1'b1;
                    if (phase_q == CHOCOLATE) begin
                        state_n    = DONE;
                        finished_n = 1'b1;
                        valves_n   = 5'b00000;
                        ticks_n    = TW'(DONE_TICKS);
                    end else begin
                        phase_n  = nxt;
                        ticks_n  = TW'(phase_duration(cur_recipe, nxt));
                        valves_n = valve_mask(cur_recipe, nxt);
                    end
                end else if (tick) begin
                    ticks_n = ticks_q - TW'(1);
                end
            end

            DONE: begin
                if (tick) begin
                    if (ticks_q <= TW'(1)) begin
                        state_n     = IDLE;
                        finished_n  = 1'b0;
                        busy_n      = 1'b0;
                        presc_clear = 1'b1;
                    end else begin
                        ticks_n = ticks_q - TW'(1);
                    end
                end
            end

            default: begin
                state_n    = IDLE;
                valves_n   = 5'b00000;
                finished_n = 1'b0;
                busy_n     = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset that aborts any brew.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            phase_q    <= WATER;
            type_q     <= 3'd0;
            ticks_q    <= '0;
            credit_q   <= 4'd0;
            change_q   <= 4'd0;
            valves_q   <= 5'b00000;
            finished_q <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_n;
            phase_q    <= phase_n;
            type_q     <= type_n;
            ticks_q    <= ticks_n;
            credit_q   <= credit_n;
            change_q   <= change_n;
            valves_q   <= valves_n;
            finished_q <= finished_n;
            busy_q     <= busy_n;
            error_q    <= error_n;
        end
    end

    assign credit    = credit_q;
    assign change    = change_q;
    assign water     = valves_q[0];
    assign coffee    = valves_q[1];
    assign sugar     = valves_q[2];
    assign milk      = valves_q[3];
    assign chocolate = valves_q[4];
    assign finished  = finished_q;
    assign busy      = busy_q;
    assign error     = error_q;

endmodule

// File: tb/tb_brew_sequencer.sv
// Scoreboard bench for brew_sequencer: stimulus queues expected output states, a monitor
// compares each new output state and how many cycles the previous one was held.
module tb_brew_sequencer;

    localparam int TICK_DIV   = 4;
    localparam int MAX_CREDIT = 9;
    localparam int DONE_TICKS = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       coin_100 = 1'b0;
    logic       coin_500 = 1'b0;
    logic       confirm = 1'b0;
    logic [2:0] coffee_type = 3'd0;
    logic [3:0] credit, change;
    logic       water, coffee, sugar, milk, chocolate;
    logic       finished, busy, error;

    always #5 clock = ~clock;

    brew_sequencer #(
        .TICK_DIV   (TICK_DIV),
        .MAX_CREDIT (MAX_CREDIT),
        .DONE_TICKS (DONE_TICKS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .coin_100    (coin_100),
        .coin_500    (coin_500),
        .coffee_type (coffee_type),
        .confirm     (confirm),
        .credit      (credit),
        .change      (change),
        .water       (water),
        .coffee      (coffee),
        .sugar       (sugar),
        .milk        (milk),
        .chocolate   (chocolate),
        .finished    (finished),
        .busy        (busy),
        .error       (error)
    );

    typedef struct packed {
        logic [3:0] credit;
        logic [3:0] change;
        logic [4:0] valves;   // {water, coffee, sugar, milk, chocolate}
        logic       finished;
        logic       busy;
        logic       error;
    } obs_t;

    typedef struct {
        obs_t  val;
        int    dwell;         // cycles this state must hold; 0 = not timed
        string name;
    } exp_t;

    localparam logic [4:0] V_0 = 5'b00000;
    localparam logic [4:0] V_W = 5'b10000;
    localparam logic [4:0] V_C = 5'b01000;
    localparam logic [4:0] V_S = 5'b00100;
    localparam logic [4:0] V_M = 5'b00010;
    localparam logic [4:0] V_K = 5'b00001;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    bit   probe_req = 1'b0;

    function automatic obs_t mk(input int cr, input int ch, input logic [4:0] v,
                                input logic f, input logic b, input logic e);
        obs_t o;
        o.credit   = 4'(cr);
        o.change   = 4'(ch);
        o.valves   = v;
        o.finished = f;
        o.busy     = b;
        o.error    = e;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.credit   = credit;
        o.change   = change;
        o.valves   = {water, coffee, sugar, milk, chocolate};
        o.finished = finished;
        o.busy     = busy;
        o.error    = error;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("credit=%0d change=%0d valves(wcsmk)=%05b finished=%0b busy=%0b error=%0b",
                         o.credit, o.change, o.valves, o.finished, o.busy, o.error);
    endfunction

    task automatic check_val(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) $display("FAIL %s: got %0d, required %0d", name, act, req);
        else n_pass++;
    endtask

    task automatic check_obs(input string name, input obs_t act, input obs_t req);
        n_checks++;
        if (act !== req) $display("FAIL %s: got [%s], required [%s]", name, fmt(act), fmt(req));
        else n_pass++;
    endtask

    task automatic expect_obs(input string name, input obs_t v, input int dwell);
        exp_t e;
        e.val   = v;
        e.dwell = dwell;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation each time the output bundle changes (or on a probe).
    initial begin : monitor
        obs_t  prev, cur;
        exp_t  e;
        int    last_change, last_dwell;
        string last_name;
        bit    first, changed;
        first = 1'b1;
        last_change = 0;
        last_dwell = 0;
        last_name = "";
        prev = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (mon_en) begin
                cur = sample();
                changed = (cur != prev);
                check_val("valve_onehot", ($countones(cur.valves) <= 1) ? 1 : 0, 1);
                if (first || changed || probe_req) begin
                    if (!first && changed && last_dwell != 0)
                        check_val({last_name, "_cycles"}, cyc - last_change, last_dwell);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_output: got [%s], required no change", fmt(cur));
                        last_change = cyc;
                        last_dwell = 0;
                    end else begin
                        e = exp_q.pop_front();
                        check_obs(e.name, cur, e.val);
                        if (first || changed) begin
                            last_change = cyc;
                            last_dwell  = e.dwell;
                            last_name   = e.name;
                        end
                    end
                    first = 1'b0;
                    probe_req = 1'b0;
                    prev = cur;
                end
            end
        end
    end

    // Drive one-cycle pulses on the selected inputs; entered and left on a falling edge.
    task automatic pulse(input logic c100, input logic c500, input logic conf);
        coin_100 = c100;
        coin_500 = c500;
        confirm  = conf;
        @(negedge clock);
        coin_100 = 1'b0;
        coin_500 = 1'b0;
        confirm  = 1'b0;
        @(negedge clock);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL %s_timeout: %0d outputs still pending after %0d cycles, required 0",
                     name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    // Compare the current outputs even though nothing is expected to change.
    task automatic probe(input string name, input obs_t v);
        expect_obs(name, v, 0);
        @(posedge clock);
        probe_req = 1'b1;
        @(negedge clock);
        drain(name, 4);
    endtask

    // Wait for milk (sel=0) or finished (sel=1) to go high, within a cycle budget.
    task automatic wait_out(input string name, input int sel, input int budget);
        int n = 0;
        while (((sel == 0) ? milk : finished) !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (((sel == 0) ? milk : finished) !== 1'b1) begin
            n_checks++;
            $display("FAIL %s_timeout: output not seen after %0d cycles, required high", name, budget);
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        repeat (3) @(negedge clock);
        expect_obs("reset_state", mk(0, 0, V_0, 0, 0, 0), 0);
        mon_en = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        drain("reset", 10);

        // Type 2 with 5 credit: every valve runs, chocolate twice as long.
        expect_obs("t1_coin500", mk(5, 0, V_0, 0, 0, 0), 0);
        pulse(1'b0, 1'b1, 1'b0);
        drain("t1_coin", 10);
        coffee_type = 3'd2;
        expect_obs("t1_water",     mk(0, 1, V_W, 0, 1, 0), 4);
        expect_obs("t1_coffee",    mk(0, 1, V_C, 0, 1, 0), 4);
        expect_obs("t1_sugar",     mk(0, 1, V_S, 0, 1, 0), 4);
        expect_obs("t1_milk",      mk(0, 1, V_M, 0, 1, 0), 4);
        expect_obs("t1_chocolate", mk(0, 1, V_K, 0, 1, 0), 8);
        expect_obs("t1_done",      mk(0, 1, V_0, 1, 1, 0), 8);
        expect_obs("t1_idle",      mk(0, 1, V_0, 0, 0, 0), 0);
        pulse(1'b0, 1'b0, 1'b1);
        coffee_type = 3'd4;
        drain("t1_brew", 200);

        // Insufficient credit, then top up and brew type 1 (zero-length sugar/chocolate).
        expect_obs("t2_coin_a",    mk(1, 0, V_0, 0, 0, 0), 0);
        expect_obs("t2_coin_b",    mk(2, 0, V_0, 0, 0, 0), 0);
        expect_obs("t2_reject",    mk(2, 0, V_0, 0, 0, 1), 0);
        expect_obs("t2_coin_c",    mk(3, 0, V_0, 0, 0, 0), 0);
        expect_obs("t2_water",     mk(0, 0, V_W, 0, 1, 0), 4);
        expect_obs("t2_coffee",    mk(0, 0, V_C, 0, 1, 0), 8);
        expect_obs("t2_sugar0",    mk(0, 0, V_0, 0, 1, 0), 1);
        expect_obs("t2_milk",      mk(0, 0, V_M, 0, 1, 0), 8);
        expect_obs("t2_choc0",     mk(0, 0, V_0, 0, 1, 0), 1);
        expect_obs("t2_done",      mk(0, 0, V_0, 1, 1, 0), 8);
        expect_obs("t2_idle",      mk(0, 0, V_0, 0, 0, 0), 0);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        coffee_type = 3'd1;
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        drain("t2_brew", 200);

        // Saturation at 9 and an invalid drink type.
        expect_obs("t3_coin500",    mk(5, 0, V_0, 0, 0, 0), 0);
        expect_obs("t3_saturate",   mk(9, 0, V_0, 0, 0, 0), 0);
        expect_obs("t3_bad_type",   mk(9, 0, V_0, 0, 0, 1), 0);
        expect_obs("t3_error_clear", mk(9, 0, V_0, 0, 0, 0), 0);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        coffee_type = 3'd6;
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        drain("t3", 20);
        pulse(1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clock);
        probe("t3_saturate_hold", mk(9, 0, V_0, 0, 0, 0));

        // Type 0 from credit 9: three consecutive one-cycle empty phases.
        coffee_type = 3'd0;
        expect_obs("t4_water",  mk(0, 7, V_W, 0, 1, 0), 8);
        expect_obs("t4_coffee", mk(0, 7, V_C, 0, 1, 0), 8);
        expect_obs("t4_empty3", mk(0, 7, V_0, 0, 1, 0), 3);
        expect_obs("t4_done",   mk(0, 7, V_0, 1, 1, 0), 8);
        expect_obs("t4_idle",   mk(0, 7, V_0, 0, 0, 0), 0);
        pulse(1'b0, 1'b0, 1'b1);
        drain("t4_brew", 200);
        expect_obs("t4_coin_both", mk(6, 0, V_0, 0, 0, 0), 0);
        pulse(1'b1, 1'b1, 1'b0);
        drain("t4_coin", 10);

        // Reset asserted in the milk phase, with a coin switch held through reset.
        coffee_type = 3'd1;
        expect_obs("t5_water",   mk(0, 3, V_W, 0, 1, 0), 4);
        expect_obs("t5_coffee",  mk(0, 3, V_C, 0, 1, 0), 8);
        expect_obs("t5_sugar0",  mk(0, 3, V_0, 0, 1, 0), 1);
        expect_obs("t5_milk",    mk(0, 3, V_M, 0, 1, 0), 1);
        expect_obs("t5_reset_abort", mk(0, 0, V_0, 0, 0, 0), 0);
        pulse(1'b0, 1'b0, 1'b1);
        wait_out("t5_milk", 0, 100);
        reset = 1'b0;
        coin_100 = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        coin_100 = 1'b0;
        repeat (2) @(negedge clock);
        drain("t5", 10);
        probe("t5_no_credit", mk(0, 0, V_0, 0, 0, 0));

        // Coin and confirm edges while busy are discarded; no second brew follows.
        expect_obs("t6_coin_a", mk(1, 0, V_0, 0, 0, 0), 0);
        expect_obs("t6_coin_b", mk(2, 0, V_0, 0, 0, 0), 0);
        expect_obs("t6_water",  mk(0, 0, V_W, 0, 1, 0), 8);
        expect_obs("t6_coffee", mk(0, 0, V_C, 0, 1, 0), 8);
        expect_obs("t6_empty3", mk(0, 0, V_0, 0, 1, 0), 3);
        expect_obs("t6_done",   mk(0, 0, V_0, 1, 1, 0), 8);
        expect_obs("t6_idle",   mk(0, 0, V_0, 0, 0, 0), 0);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        coffee_type = 3'd0;
        pulse(1'b0, 1'b0, 1'b1);
        coffee_type = 3'd7;
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        wait_out("t6_finished", 1, 100);
        pulse(1'b1, 1'b1, 1'b1);
        drain("t6_brew", 200);
        repeat (40) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/brew_sequencer.md
Name: brew_sequencer

Overview:
Central controller for the coffee machine datapath. It accumulates coin credit, validates the selected drink against a price table and computes change. It then sequences the five ingredient valves, using per-drink durations in one-second ticks, and signals completion. It replaces the loose coin-comparator/timer/fsm chain with one clocked scheduler that drives the display encoders and valve outputs.

Parameters:
TICK_DIV, 50_000_000, clock cycles per one-second tick (benches use 4)
MAX_CREDIT, 9, credit saturation value in 100-unit coins
DONE_TICKS, 2, ticks that finished stays high

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
coin_100  in  1  coin switch, +1 credit on rising edge
coin_500  in  1  coin switch, +5 credit on rising edge
coffee_type  in  3  drink select; 0..4 valid, 5..7 invalid
confirm  in  1  purchase request, acts on rising edge
credit  out  4  current credit in 100-unit coins
change  out  4  change from the last accepted purchase
water, coffee, sugar, milk, chocolate  out  1 each  valve drives
finished  out  1  drink complete
busy  out  1  high during DISPENSE and DONE
error  out  1  last confirm rejected

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, credit=0, change=0, all valves=0, finished=0, busy=0, error=0, prescaler=0.
  - Edge-detect history registers load the current input values, so switches held through reset do not fire.
  - Reset applies in every state and aborts dispensing within one cycle.
- All outputs are registered. Rising edges are detected against the previous-cycle sample, giving one cycle of latency from input change to action.
- Price table (coffee_type: price; water/coffee/sugar/milk/chocolate seconds):
  - 0: 2; 2/2/0/0/0
  - 1: 3; 1/2/0/2/0
  - 2: 4; 1/1/1/1/2
  - 3: 3; 2/0/1/0/3
  - 4: 2; 2/2/1/0/0
- IDLE:
  - A coin edge adds 1 or 5; simultaneous edges add 6. The sum saturates at MAX_CREDIT.
  - Any coin edge clears error and clears change to 0.
- IDLE, confirm edge:
  - If type>4 or credit<price: error=1, credit is unchanged, stay in IDLE.
  - Otherwise: change=credit-price, credit=0, error=0, phase=WATER, prescaler=0, busy=1, go to DISPENSE.
  - Type and recipe are latched at acceptance; later coffee_type changes are ignored until IDLE.
- DISPENSE:
  - Phases run in fixed order: WATER, COFFEE, SUGAR, MILK, CHOCOLATE.
  - A phase with nonzero duration d holds only its valve high for exactly d*TICK_DIV cycles. The valve rises on the first cycle of the phase.
  - A zero-duration phase takes exactly 1 cycle with all valves low.
  - The prescaler restarts at 0 on every phase entry.
  - After CHOCOLATE, go to DONE. At most one valve is high at any time.
- DONE:
  - finished=1 and valves=0 for DONE_TICKS*TICK_DIV cycles.
  - Then go to IDLE with finished=0 and busy=0. change holds until the next coin edge.
- Outside IDLE, coin and confirm edges are discarded, not queued.
- Arithmetic: credit and change are 4-bit unsigned. Subtraction happens only when credit>=price, so it never wraps.

Decomposition:
- Package brew_pkg holds:
  - state_t enum (IDLE, DISPENSE, DONE)
  - phase_t enum (WATER..CHOCOLATE)
  - recipe_t struct (price[3:0], five 2-bit durations)
  - a constant recipe table indexed by coffee_type, plus an invalid-type predicate
- One sub-module, tick_prescaler (clock, reset, clear, tick), wraps at TICK_DIV-1 and pulses tick for one cycle.

Test Plan:
- Insert coin_500, select type 2, confirm -> credit=5, then credit=0, change=1. Valves run water 4, coffee 4, sugar 4, milk 4, chocolate 8 cycles (TICK_DIV=4). finished=1 for 8 cycles, then IDLE.
- Two coin_100 edges, select type 1, confirm -> error=1, credit=2, stays IDLE. One more coin_100 -> error=0, credit=3. Confirm -> change=0, and the milk-phase timing is checked.
- Select type 6 with credit=9 -> error=1, credit=9. Two coin_500 edges -> credit saturates at 9.
- Type 0 dispense -> water 8 cycles, coffee 8 cycles, then sugar, milk and chocolate take 1 cycle each with all valves low. Check one-hot valves every cycle.
- Assert reset low during the MILK phase of type 1 -> next cycle all outputs 0, state IDLE. Held coin switch causes no credit after release of reset.
- Coin and confirm edges during DISPENSE -> ignored: credit stays 0, and there is no second brew after DONE.
